// File: rtl/onehot_decoder_seq_if.sv
// rtl/onehot_decoder_seq_if.sv - handshake and output bundle for the sequenced 3-to-8 decoder
interface onehot_decoder_seq_if;
    logic [2:0] A;
    logic       A_VALID;
    logic       A_READY;
    logic       SCAN_EN;
    logic [7:0] O;
    logic       O_VALID;
    logic       BUSY;

    // Control logic side: offers codes and the scan request, observes the one-hot output
    modport master (
        output A,
        output A_VALID,
        output SCAN_EN,
        input  A_READY,
        input  O,
        input  O_VALID,
        input  BUSY
    );

    // Decoder side
    modport slave (
        input  A,
        input  A_VALID,
        input  SCAN_EN,
        output A_READY,
        output O,
        output O_VALID,
        output BUSY
    );
endinterface

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - sequenced 3-to-8 one-hot decoder with hold, gap and scan modes
module onehot_decoder_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    onehot_decoder_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2,
        SCAN  = 2'd3
    } state_t;

    // Counter reload values, evaluated at counter width so every compare is CNT_W wide.
    // A counter value of N means N further cycles remain after the current one.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [2:0]       idx_inc;
    logic [7:0]       o_q, o_n;
    logic             o_valid_q;
    logic             busy_q;
    logic             accept;
    logic             cnt_done;

    // Codes are only taken in IDLE, and a pending scan request blocks them
    assign bus.A_READY = (state == IDLE) & ~bus.SCAN_EN;
    assign accept      = bus.A_VALID & bus.A_READY;
    assign cnt_done    = (cnt == CNT_ZERO);
    assign idx_inc     = idx + 3'd1;

    assign bus.O       = o_q;
    assign bus.O_VALID = o_valid_q;
    assign bus.BUSY    = busy_q;

    // Next-state, counter, scan index and output-pattern selection
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        o_n     = o_q;

        unique case (state)
            IDLE: begin
                // Scan request wins over a simultaneous code; the code stays unconsumed
                if (bus.SCAN_EN) begin
                    state_n = SCAN;
                    idx_n   = 3'd0;
                    o_n     = 8'h01;
                    cnt_n   = HOLD_LOAD;
                end else if (accept) begin
                    state_n = DRIVE;
                    o_n     = 8'h01 << bus.A;
                    cnt_n   = HOLD_LOAD;
                end else begin
                    o_n     = 8'h00;
                    cnt_n   = CNT_ZERO;
                end
            end

            DRIVE: begin
                if (cnt_done) begin
                    o_n = 8'h00;
                    if (HAS_GAP) begin
                        state_n = GAP;
                        cnt_n   = GAP_LOAD;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = CNT_ZERO;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            GAP: begin
                o_n = 8'h00;
                if (cnt_done) begin
                    state_n = IDLE;
                    cnt_n   = CNT_ZERO;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            SCAN: begin
                // SCAN_EN is only sampled at slot boundaries so a slot is never cut short
                if (cnt_done) begin
                    if (bus.SCAN_EN) begin
                        idx_n = idx_inc;
                        o_n   = 8'h01 << idx_inc;
                        cnt_n = HOLD_LOAD;
                    end else begin
                        o_n   = 8'h00;
                        idx_n = 3'd0;
                        if (HAS_GAP) begin
                            state_n = GAP;
                            cnt_n   = GAP_LOAD;
                        end else begin
                            state_n = IDLE;
                            cnt_n   = CNT_ZERO;
                        end
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = CNT_ZERO;
                idx_n   = 3'd0;
                o_n     = 8'h00;
            end
        endcase
    end

    // State, counter and registered outputs; reset clears everything immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= CNT_ZERO;
            idx       <= 3'd0;
            o_q       <= 8'h00;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            o_q       <= o_n;
            o_valid_q <= |o_n;
            busy_q    <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - scoreboard bench for the sequenced 3-to-8 decoder
module tb_onehot_decoder_seq;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp0_q[$];

    onehot_decoder_seq_if bus ();
    onehot_decoder_seq_if bus0 ();

    onehot_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    onehot_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic wait_ready(output int c);
        int k = 0;
        while (bus.A_READY !== 1'b1 && k < 40) begin
            tick(1);
            k++;
        end
        chk("ready_timeout", k < 40, 1);
        c = cyc;
    endtask

    task automatic wait_ready0(output int c);
        int k = 0;
        while (bus0.A_READY !== 1'b1 && k < 40) begin
            tick(1);
            k++;
        end
        chk("ready0_timeout", k < 40, 1);
        c = cyc;
    endtask

    task automatic push_n(input logic [7:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    // Monitor for the GAP=1 instance: every nonzero output cycle consumes one expectation
    always @(negedge CLK) begin
        if (!RST && (bus.O_VALID !== 1'b0 || bus.O !== 8'h00)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL mon_unexpected: got O=%h O_VALID=%b, need no output", bus.O, bus.O_VALID);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.O !== e || bus.O_VALID !== 1'b1) begin
                    n_err++;
                    $display("FAIL mon_o: got O=%h O_VALID=%b, need O=%h O_VALID=1", bus.O, bus.O_VALID, e);
                end
            end
        end
    end

    // Monitor for the GAP=0 instance
    always @(negedge CLK) begin
        if (!RST && (bus0.O_VALID !== 1'b0 || bus0.O !== 8'h00)) begin
            n_vec++;
            if (exp0_q.size() == 0) begin
                n_err++;
                $display("FAIL mon0_unexpected: got O=%h O_VALID=%b, need no output", bus0.O, bus0.O_VALID);
            end else begin
                logic [7:0] e;
                e = exp0_q.pop_front();
                if (bus0.O !== e || bus0.O_VALID !== 1'b1) begin
                    n_err++;
                    $display("FAIL mon0_o: got O=%h O_VALID=%b, need O=%h O_VALID=1", bus0.O, bus0.O_VALID, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, bad;
        logic [7:0] e;

        bus.A = 3'd0;  bus.A_VALID = 1'b0;  bus.SCAN_EN = 1'b0;
        bus0.A = 3'd0; bus0.A_VALID = 1'b0; bus0.SCAN_EN = 1'b0;

        // Reset state
        RST = 1'b1;
        tick(2);
        chk("rst_o", bus.O, 8'h00);
        chk("rst_o_valid", bus.O_VALID, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_a_ready", bus.A_READY, 1);
        RST = 1'b0;
        tick(1);

        // Reset mid-drive: A=2 accepted, RST in the 2nd DRIVE cycle
        bus.A = 3'd2;
        bus.A_VALID = 1'b1;
        wait_ready(c0);
        push_n(8'h04, 1);
        tick(1);
        bus.A_VALID = 1'b0;
        chk("t1_drive", bus.O, 8'h04);
        tick(1);
        RST = 1'b1;
        #1;
        chk("t1_rst_o", bus.O, 8'h00);
        chk("t1_rst_o_valid", bus.O_VALID, 0);
        chk("t1_rst_busy", bus.BUSY, 0);
        tick(1);
        RST = 1'b0;
        #1;
        chk("t1_ready_after", bus.A_READY, 1);

        // Single decode of every code with exact hold/gap timing
        for (int code = 0; code < 8; code++) begin
            e = 8'h01 << code;
            bus.A = 3'(code);
            bus.A_VALID = 1'b1;
            wait_ready(c0);
            push_n(e, 4);
            tick(1);
            bus.A_VALID = 1'b0;
            chk("t2_first", bus.O, e);
            tick(3);
            chk("t2_last", bus.O, e);
            tick(1);
            chk("t2_gap_o", bus.O, 8'h00);
            chk("t2_gap_busy", bus.BUSY, 1);
            tick(1);
            chk("t2_ready", bus.A_READY, 1);
        end

        // Streaming with A_VALID held high; A changes while busy are ignored
        bus.A = 3'd0;
        bus.A_VALID = 1'b1;
        wait_ready(c0);
        push_n(8'h01, 4);
        tick(1);
        bus.A = 3'd5;
        tick(2);
        bus.A = 3'd7;
        wait_ready(c1);
        push_n(8'h80, 4);
        tick(1);
        bus.A = 3'd1;
        tick(1);
        bus.A = 3'd3;
        wait_ready(c2);
        push_n(8'h08, 4);
        tick(1);
        bus.A_VALID = 1'b0;
        chk("t3_period_a", c1 - c0, 6);
        chk("t3_period_b", c2 - c1, 6);
        tick(6);

        // Streaming on the GAP=0 instance
        bus0.A = 3'd0;
        bus0.A_VALID = 1'b1;
        wait_ready0(c0);
        repeat (4) exp0_q.push_back(8'h01);
        tick(1);
        bus0.A = 3'd7;
        wait_ready0(c1);
        repeat (4) exp0_q.push_back(8'h80);
        tick(1);
        bus0.A = 3'd3;
        wait_ready0(c2);
        repeat (4) exp0_q.push_back(8'h08);
        tick(1);
        bus0.A_VALID = 1'b0;
        chk("t3g0_period_a", c1 - c0, 5);
        chk("t3g0_period_b", c2 - c1, 5);
        tick(6);

        // Scan through all lines with wrap, then exit mid-slot of 8'h04
        bus.SCAN_EN = 1'b1;
        #1;
        chk("t4_ready_scan_req", bus.A_READY, 0);
        for (int s = 0; s < 9; s++) begin
            e = 8'h01 << (s % 8);
            push_n(e, 4);
        end
        push_n(8'h02, 4);
        push_n(8'h04, 4);
        tick(1);
        bad = 0;
        for (int i = 1; i <= 44; i++) begin
            if (bus.O_VALID !== 1'b1 || bus.A_READY !== 1'b0) bad++;
            if (i == 42) bus.SCAN_EN = 1'b0;
            tick(1);
        end
        chk("t4_scan_no_gap_no_ready", bad, 0);
        chk("t5_gap_o", bus.O, 8'h00);
        chk("t5_gap_busy", bus.BUSY, 1);
        chk("t5_gap_ready", bus.A_READY, 0);
        tick(1);
        chk("t5_idle_ready", bus.A_READY, 1);
        chk("t5_idle_busy", bus.BUSY, 0);

        // Contention: scan request and a valid code at the same IDLE edge
        bus.A = 3'd6;
        bus.A_VALID = 1'b1;
        bus.SCAN_EN = 1'b1;
        #1;
        chk("t6_ready", bus.A_READY, 0);
        push_n(8'h01, 4);
        tick(1);
        bus.SCAN_EN = 1'b0;
        bus.A_VALID = 1'b0;
        chk("t6_scan_o", bus.O, 8'h01);
        chk("t6_busy", bus.BUSY, 1);
        tick(5);
        chk("t6_idle_ready", bus.A_READY, 1);

        tick(2);
        chk("sb_drained", exp_q.size(), 0);
        chk("sb0_drained", exp0_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
